// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax block.
// Optional runner-up tracking is enabled by defining ARGMAX_TOP2_EN.
package argmax_pkg;

    typedef enum logic {COLLECT, HOLD} argmax_state_e;

    // Most negative two's-complement value; slice the top DATA_W bits for narrower scores.
    localparam logic [63:0] MIN_SCORE = 64'h8000_0000_0000_0000;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_cmp_stage.sv
// Combinational compare-and-select for one incoming score against the running best.
// Runner-up ports exist only when ARGMAX_TOP2_EN is defined.
module argmax_cmp_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                     i_first,
`ifdef ARGMAX_TOP2_EN
    input  logic                     i_second,
    input  logic signed [DATA_W-1:0] i_sec_val,
    input  logic        [IDX_W-1:0]  i_sec_idx,
    output logic signed [DATA_W-1:0] o_sec_val,
    output logic        [IDX_W-1:0]  o_sec_idx,
`endif
    input  logic signed [DATA_W-1:0] i_best_val,
    input  logic        [IDX_W-1:0]  i_best_idx,
    input  logic signed [DATA_W-1:0] i_new_val,
    input  logic        [IDX_W-1:0]  i_new_idx,
    output logic signed [DATA_W-1:0] o_best_val,
    output logic        [IDX_W-1:0]  o_best_idx
);

    logic w_gt_best;

    // Strictly greater only, so ties keep the earlier (lower) index.
    assign w_gt_best = i_new_val > i_best_val;

    always_comb begin
        o_best_val = i_best_val;
        o_best_idx = i_best_idx;
        if (i_first || w_gt_best) begin
            o_best_val = i_new_val;
            o_best_idx = i_new_idx;
        end
    end

`ifdef ARGMAX_TOP2_EN
    always_comb begin
        o_sec_val = i_sec_val;
        o_sec_idx = i_sec_idx;
        if (i_first) begin
            o_sec_val = argmax_pkg::MIN_SCORE[63 -: DATA_W];
            o_sec_idx = '0;
        end else if (w_gt_best) begin
            o_sec_val = i_best_val;
            o_sec_idx = i_best_idx;
        end else if (i_second || (i_new_val > i_sec_val)) begin
            // The second score of a frame always fills the empty runner-up slot.
            o_sec_val = i_new_val;
            o_sec_idx = i_new_idx;
        end
    end
`endif

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: collects N_CLASSES signed scores, then holds winner until accepted.
// Define ARGMAX_TOP2_EN to add runner-up index/score outputs.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned IDX_W    = idx_w(N_CLASSES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic signed [DATA_W-1:0] i_in_score,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [N_CLASSES-1:0]     o_out_onehot,
    output logic [IDX_W-1:0]         o_out_idx,
`ifdef ARGMAX_TOP2_EN
    output logic [IDX_W-1:0]         o_out_idx2,
    output logic signed [DATA_W-1:0] o_out_max2,
`endif
    output logic signed [DATA_W-1:0] o_out_max
);

    argmax_state_e r_state, w_state_nxt;
    logic [IDX_W-1:0] r_count, w_count_nxt;
    logic r_rdy_en;
    logic w_accept, w_last, w_load;

    logic signed [DATA_W-1:0] r_best_val, w_best_val;
    logic        [IDX_W-1:0]  r_best_idx, w_best_idx;
    logic [N_CLASSES-1:0]     w_onehot;

    logic [N_CLASSES-1:0]     r_onehot;
    logic [IDX_W-1:0]         r_idx;
    logic signed [DATA_W-1:0] r_max;

    // r_rdy_en keeps in_ready low until the first edge after reset release.
    assign o_in_ready  = (r_state == COLLECT) && r_rdy_en;
    assign o_out_valid = (r_state == HOLD);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last      = (r_count == IDX_W'(N_CLASSES - 1));
    assign w_load      = w_accept && !i_clear;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (i_clear) begin
            w_state_nxt = COLLECT;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_last) begin
                            w_state_nxt = HOLD;
                            w_count_nxt = '0;
                        end else begin
                            w_count_nxt = r_count + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        w_state_nxt = COLLECT;
                    end
                end
                default: begin
                    w_state_nxt = COLLECT;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= COLLECT;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_rdy_en <= 1'b1;
        end
    end

`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_W-1:0] r_sec_val, w_sec_val;
    logic        [IDX_W-1:0]  r_sec_idx, w_sec_idx;
    logic        [IDX_W-1:0]  r_idx2;
    logic signed [DATA_W-1:0] r_max2;
`endif

    argmax_cmp_stage #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) u_cmp (
        .i_first   (r_count == '0),
`ifdef ARGMAX_TOP2_EN
        .i_second  (r_count == IDX_W'(1)),
        .i_sec_val (r_sec_val),
        .i_sec_idx (r_sec_idx),
        .o_sec_val (w_sec_val),
        .o_sec_idx (w_sec_idx),
`endif
        .i_best_val(r_best_val),
        .i_best_idx(r_best_idx),
        .i_new_val (i_in_score),
        .i_new_idx (r_count),
        .o_best_val(w_best_val),
        .o_best_idx(w_best_idx)
    );

    always_comb begin
        w_onehot = '0;
        for (int unsigned i = 0; i < N_CLASSES; i++) begin
            w_onehot[i] = (w_best_idx == IDX_W'(i));
        end
    end

    // Running registers need no explicit invalidate: count==0 forces a fresh load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_val <= MIN_SCORE[63 -: DATA_W];
            r_best_idx <= '0;
        end else if (w_load) begin
            r_best_val <= w_best_val;
            r_best_idx <= w_best_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_onehot <= '0;
            r_idx    <= '0;
            r_max    <= '0;
        end else if (w_load && w_last) begin
            r_onehot <= w_onehot;
            r_idx    <= w_best_idx;
            r_max    <= w_best_val;
        end
    end

`ifdef ARGMAX_TOP2_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_val <= MIN_SCORE[63 -: DATA_W];
            r_sec_idx <= '0;
        end else if (w_load) begin
            r_sec_val <= w_sec_val;
            r_sec_idx <= w_sec_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx2 <= '0;
            r_max2 <= '0;
        end else if (w_load && w_last) begin
            r_idx2 <= w_sec_idx;
            r_max2 <= w_sec_val;
        end
    end

    assign o_out_idx2 = r_idx2;
    assign o_out_max2 = r_max2;
`endif

    assign o_out_onehot = r_onehot;
    assign o_out_idx    = r_idx;
    assign o_out_max    = r_max;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream (N_CLASSES=10, DATA_W=32); checks runner-up when ARGMAX_TOP2_EN.
module tb_argmax_stream;

    localparam int N = 10;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_clear = 1'b0;
    logic                i_in_valid = 1'b0;
    logic                i_out_ready = 1'b0;
    logic signed [W-1:0] i_in_score = '0;
    logic                o_in_ready;
    logic                o_out_valid;
    logic [N-1:0]        o_out_onehot;
    logic [3:0]          o_out_idx;
    logic signed [W-1:0] o_out_max;
`ifdef ARGMAX_TOP2_EN
    logic [3:0]          o_out_idx2;
    logic signed [W-1:0] o_out_max2;
`endif

    argmax_stream #(
        .N_CLASSES(N),
        .DATA_W   (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (i_clear),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_score  (i_in_score),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_onehot(o_out_onehot),
        .o_out_idx   (o_out_idx),
`ifdef ARGMAX_TOP2_EN
        .o_out_idx2  (o_out_idx2),
        .o_out_max2  (o_out_max2),
`endif
        .o_out_max   (o_out_max)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic signed [W-1:0] scores [N];
    localparam logic signed [W-1:0] MINV = 32'sh8000_0000;

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic push(input logic signed [W-1:0] v, input int gap);
        int t;
        for (int g = 0; g < gap; g++) @(negedge clk);
        i_in_valid = 1'b1;
        i_in_score = v;
        t = 0;
        while (!o_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_in_ready) begin
            n_chk++; n_err++;
            $display("FAIL push_timeout in_ready=%b required=1", o_in_ready);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < N; i++) begin
            push(scores[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic test_reset;
        #1;
        n_chk++; if (o_in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", o_in_ready); end
        n_chk++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", o_out_valid); end
        n_chk++; if (o_out_onehot !== '0 || o_out_idx !== '0 || o_out_max !== '0) begin
            n_err++; $display("FAIL rst_outputs onehot=%b idx=%0d max=%0d exp=0", o_out_onehot, o_out_idx, o_out_max);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== '0 || o_out_max2 !== '0) begin
            n_err++; $display("FAIL rst_top2 idx2=%0d max2=%0d exp=0", o_out_idx2, o_out_max2);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_release_ready got=%b exp=0", o_in_ready); end
        @(negedge clk);
        n_chk++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ready got=%b exp=1", o_in_ready); end
    endtask

    task automatic test_basic;
        scores = '{3, -7, 12, 5, 12, 0, -1, 9, 2, 4};
        send_frame(0);
        n_chk++; if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
            n_err++; $display("FAIL basic_hold valid=%b ready=%b exp 1/0", o_out_valid, o_in_ready);
        end
        n_chk++; if (o_out_idx !== 4'd2 || o_out_max !== 12) begin
            n_err++; $display("FAIL basic_result idx=%0d max=%0d exp 2/12", o_out_idx, o_out_max);
        end
        n_chk++; if (o_out_onehot !== 10'b0000000100) begin
            n_err++; $display("FAIL basic_onehot got=%b exp=0000000100", o_out_onehot);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== 4'd4 || o_out_max2 !== 12) begin
            n_err++; $display("FAIL basic_top2 idx2=%0d max2=%0d exp 4/12", o_out_idx2, o_out_max2);
        end
`endif
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
        n_chk++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_release valid=%b ready=%b exp 0/1", o_out_valid, o_in_ready);
        end
    endtask

    task automatic test_all_min;
        for (int i = 0; i < N; i++) scores[i] = MINV;
        send_frame(0);
        n_chk++; if (o_out_idx !== 4'd0 || o_out_max !== MINV || o_out_onehot !== 10'b1) begin
            n_err++; $display("FAIL allmin_result idx=%0d max=%0d onehot=%b exp 0/%0d/1", o_out_idx, o_out_max, o_out_onehot, MINV);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== 4'd1 || o_out_max2 !== MINV) begin
            n_err++; $display("FAIL allmin_top2 idx2=%0d max2=%0d exp 1/%0d", o_out_idx2, o_out_max2, MINV);
        end
`endif
        i_out_ready = 1'b1;
        @(negedge clk);
        i_out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        scores = '{1, 2, 3, 4, 5, 6, 100, 7, 8, 9};
        send_frame(0);
        i_in_valid = 1'b1;
        i_in_score = 555;
        for (int c = 0; c < 5; c++) begin
            n_chk++; if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 || o_out_idx !== 4'd6 || o_out_max !== 100
                         || o_out_onehot !== 10'b0001000000) begin
                n_err++; $display("FAIL bp_stable c=%0d valid=%b ready=%b idx=%0d max=%0d exp 1/0/6/100",
                                  c, o_out_valid, o_in_ready, o_out_idx, o_out_max);
            end
            @(negedge clk);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== 4'd9 || o_out_max2 !== 9) begin
            n_err++; $display("FAIL bp_top2 idx2=%0d max2=%0d exp 9/9", o_out_idx2, o_out_max2);
        end
`endif
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        n_chk++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_bubble ready=%b exp=0", o_in_ready); end
        @(negedge clk);
        i_out_ready = 1'b0;
        n_chk++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release ready=%b valid=%b exp 1/0", o_in_ready, o_out_valid);
        end
    endtask

    task automatic test_clear;
        push(50, 0); push(60, 0); push(70, 0); push(80, 0);
        i_clear = 1'b1;
        i_in_valid = 1'b1;
        i_in_score = 1000;
        @(negedge clk);
        i_clear = 1'b0;
        i_in_valid = 1'b0;
        n_chk++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_err++; $display("FAIL clr_partial valid=%b ready=%b exp 0/1", o_out_valid, o_in_ready);
        end
        scores = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 7};
        send_frame(0);
        n_chk++; if (o_out_valid !== 1'b1 || o_out_idx !== 4'd9 || o_out_max !== 7 || o_out_onehot !== 10'b1000000000) begin
            n_err++; $display("FAIL clr_frame valid=%b idx=%0d max=%0d onehot=%b exp 1/9/7", o_out_valid, o_out_idx, o_out_max, o_out_onehot);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== 4'd0 || o_out_max2 !== -1) begin
            n_err++; $display("FAIL clr_top2 idx2=%0d max2=%0d exp 0/-1", o_out_idx2, o_out_max2);
        end
`endif
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        n_chk++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_idx !== 4'd9 || o_out_max !== 7) begin
            n_err++; $display("FAIL clr_hold valid=%b ready=%b idx=%0d max=%0d exp 0/1/9/7", o_out_valid, o_in_ready, o_out_idx, o_out_max);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 6; i++) push(10 * (i + 1), 0);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_idx !== '0 || o_out_max !== '0 || o_out_onehot !== '0) begin
            n_err++; $display("FAIL arst_frame ready=%b valid=%b idx=%0d max=%0d onehot=%b exp all 0",
                              o_in_ready, o_out_valid, o_out_idx, o_out_max, o_out_onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scores = '{-3, 8, -3, 8, 1, 1, 0, 0, -8, 2};
        send_frame(0);
        n_chk++; if (o_out_valid !== 1'b1 || o_out_idx !== 4'd1 || o_out_max !== 8) begin
            n_err++; $display("FAIL arst_next valid=%b idx=%0d max=%0d exp 1/1/8", o_out_valid, o_out_idx, o_out_max);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== 4'd3 || o_out_max2 !== 8) begin
            n_err++; $display("FAIL arst_top2 idx2=%0d max2=%0d exp 3/8", o_out_idx2, o_out_max2);
        end
`endif
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (o_out_valid !== 1'b0 || o_out_idx !== '0 || o_out_max !== '0 || o_out_onehot !== '0) begin
            n_err++; $display("FAIL arst_hold valid=%b idx=%0d max=%0d onehot=%b exp all 0", o_out_valid, o_out_idx, o_out_max, o_out_onehot);
        end
`ifdef ARGMAX_TOP2_EN
        n_chk++; if (o_out_idx2 !== '0 || o_out_max2 !== '0) begin
            n_err++; $display("FAIL arst_hold_top2 idx2=%0d max2=%0d exp 0/0", o_out_idx2, o_out_max2);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic signed [W-1:0] e_max, e_max2;
        int e_idx, e_idx2;
        i_out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) scores[i] = int'($urandom_range(0, 8)) - 4;
            e_idx = 0; e_max = scores[0]; e_idx2 = 0; e_max2 = '0;
            for (int i = 1; i < N; i++) begin
                if (scores[i] > e_max) begin
                    e_idx2 = e_idx; e_max2 = e_max; e_idx = i; e_max = scores[i];
                end else if (i == 1 || scores[i] > e_max2) begin
                    e_idx2 = i; e_max2 = scores[i];
                end
            end
            send_frame(2);
            n_chk++; if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
                n_err++; $display("FAIL b2b_hold f=%0d valid=%b ready=%b exp 1/0", f, o_out_valid, o_in_ready);
            end
            n_chk++; if (o_out_idx !== 4'(e_idx) || o_out_max !== e_max || o_out_onehot !== (10'b1 << e_idx)) begin
                n_err++; $display("FAIL b2b_result f=%0d idx=%0d max=%0d onehot=%b exp %0d/%0d", f, o_out_idx, o_out_max, o_out_onehot, e_idx, e_max);
            end
`ifdef ARGMAX_TOP2_EN
            n_chk++; if (o_out_idx2 !== 4'(e_idx2) || o_out_max2 !== e_max2) begin
                n_err++; $display("FAIL b2b_top2 f=%0d idx2=%0d max2=%0d exp %0d/%0d", f, o_out_idx2, o_out_max2, e_idx2, e_max2);
            end
`endif
            @(negedge clk);
            n_chk++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_bubble f=%0d valid=%b ready=%b exp 0/1", f, o_out_valid, o_in_ready);
            end
        end
        i_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_min();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
